// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings,
// burst controller state type and a counter-sizing helper.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  typedef enum logic [1:0] {
    BURST_IDLE  = 2'b00,
    BURST_SHIFT = 2'b01,
    BURST_DONE  = 2'b10
  } burst_state_e;

  // Number of bits needed to count 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst serialiser control: tracks the remaining shifts of a burst and
// produces the load/shift strobes for the data register plus busy/done.
module usr_burst_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic start,
  output logic load,
  output logic shift,
  output logic busy,
  output logic done
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  burst_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and shift counter; an async reset aborts any burst without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BURST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: DONE lasts one edge whatever en does; the cnt==0 cycle ends
  // the burst instead of shifting, so busy spans exactly WIDTH enabled cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      BURST_SHIFT: begin
        if (en) begin
          if (cnt_q == '0) begin
            state_d = BURST_DONE;
          end else begin
            shift = 1'b1;
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = BURST_IDLE;
        if (en && start) begin
          state_d = BURST_SHIFT;
          cnt_d   = CNT_LAST;
          load    = 1'b1;
        end
      end
    endcase
  end

  assign busy = (state_q == BURST_SHIFT);
  assign done = (state_q == BURST_DONE);

endmodule

// File: rtl/univ_shift_reg.sv
// Universal register: mode-selected hold/load/shift/rotate/clear with serial
// ports at both ends, plus an LSB-first burst serialiser driven by start.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             sout_lsb,
  output logic             sout_msb,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             burst_load;
  logic             burst_shift;

  usr_burst_ctrl #(
    .WIDTH(WIDTH)
  ) u_burst_ctrl (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .start(start),
    .load (burst_load),
    .shift(burst_shift),
    .busy (busy),
    .done (done)
  );

  // Data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= RESET_VAL;
    else        q_q <= q_d;
  end

  // Next data: burst load/shift first, mode ignored while a burst owns q.
  always_comb begin
    q_d = q_q;
    if (burst_load) begin
      q_d = d;
    end else if (burst_shift) begin
      q_d = {sin_r, q_q[WIDTH-1:1]};
    end else if (en && !busy) begin
      unique case (mode)
        MODE_LOAD: q_d = d;
        MODE_SHL:  q_d = {q_q[WIDTH-2:0], sin_l};
        MODE_SHR:  q_d = {sin_r, q_q[WIDTH-1:1]};
        MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
        MODE_CLR:  q_d = '0;
        default:   q_d = q_q;
      endcase
    end
  end

  assign q        = q_q;
  assign sout_lsb = q_q[0];
  assign sout_msb = q_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: a 4-bit and an 8-bit (RESET_VAL=A5) instance share
// stimulus; an abstract model predicts both, plus directed literal checks.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] d = 8'd0;
  logic       sin_l = 1'b0, sin_r = 1'b0, start = 1'b0;

  logic [3:0] q4;
  logic       sl4, sm4, busy4, done4;
  logic [7:0] q8;
  logic       sl8, sm8, busy8, done8;

  int n_cmp = 0;
  int n_bad = 0;
  bit run_cmp = 1'b0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(4), .RESET_VAL(4'h0)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d[3:0]),
    .sin_l(sin_l), .sin_r(sin_r), .start(start),
    .q(q4), .sout_lsb(sl4), .sout_msb(sm4), .busy(busy4), .done(done4)
  );

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d),
    .sin_l(sin_l), .sin_r(sin_r), .start(start),
    .q(q8), .sout_lsb(sl8), .sout_msb(sm8), .busy(busy8), .done(done8)
  );

  // Model: q value, enabled busy cycles remaining in a burst, done flag.
  typedef struct {
    logic [7:0] q;
    int         rem;
    bit         done;
  } mdl_t;

  mdl_t m4, m8;

  function automatic mdl_t mstep(mdl_t m, int w, bit e, logic [2:0] md,
                                 logic [7:0] di, bit sl, bit sr, bit st);
    mdl_t       n;
    logic [7:0] mask;
    n      = m;
    n.done = 1'b0;
    mask   = 8'((1 << w) - 1);
    if (!e) return n;
    if (m.rem > 0) begin
      if (m.rem == 1) begin
        n.rem  = 0;
        n.done = 1'b1;
      end else begin
        n.q   = (m.q >> 1) | (8'(sr) << (w - 1));
        n.rem = m.rem - 1;
      end
    end else if (st) begin
      n.q   = di & mask;
      n.rem = w;
    end else begin
      case (md)
        3'd1: n.q = di & mask;
        3'd2: n.q = ((m.q << 1) | 8'(sl)) & mask;
        3'd3: n.q = (m.q >> 1) | (8'(sr) << (w - 1));
        3'd4: n.q = ((m.q << 1) | (m.q >> (w - 1))) & mask;
        3'd5: n.q = (m.q >> 1) | (8'(m.q[0]) << (w - 1));
        3'd6: n.q = 8'h00;
        default: n.q = m.q;
      endcase
    end
    return n;
  endfunction

  // Model advance on each rising edge; reset is asynchronous like the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4 = '{8'h00, 0, 1'b0};
      m8 = '{8'hA5, 0, 1'b0};
    end else begin
      m4 = mstep(m4, 4, en, mode, d, sin_l, sin_r, start);
      m8 = mstep(m8, 8, en, mode, d, sin_l, sin_r, start);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge out of reset.
  always @(negedge clk) begin
    if (run_cmp && rst_n === 1'b1) begin
      chk("q4",    32'(q4),    32'(m4.q[3:0]));
      chk("slsb4", 32'(sl4),   32'(m4.q[0]));
      chk("smsb4", 32'(sm4),   32'(m4.q[3]));
      chk("busy4", 32'(busy4), 32'(m4.rem > 0));
      chk("done4", 32'(done4), 32'(m4.done));
      chk("q8",    32'(q8),    32'(m8.q));
      chk("slsb8", 32'(sl8),   32'(m8.q[0]));
      chk("smsb8", 32'(sm8),   32'(m8.q[7]));
      chk("busy8", 32'(busy8), 32'(m8.rem > 0));
      chk("done8", 32'(done8), 32'(m8.done));
    end
  end

  task automatic step(input bit e, input logic [2:0] md, input logic [7:0] dv,
                      input bit sl, input bit sr, input bit st);
    @(negedge clk);
    #1;
    en = e; mode = md; d = dv; sin_l = sl; sin_r = sr; start = st;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle8();
    for (int i = 0; i < 20; i++) begin
      if (!busy8 && !done8) return;
      step(1, 3'd0, 8'h00, 0, 0, 0);
    end
    chk("idle8_timeout", 32'(busy8), 32'(0));
  endtask

  initial begin
    logic [3:0] exp_q[3];
    logic [7:0] ser;
    int         nb8;

    // Power-on reset
    repeat (2) @(posedge clk);
    #2;
    chk("rst_q4", 32'(q4), 32'h0);
    chk("rst_q8", 32'(q8), 32'hA5);
    chk("rst_busy4", 32'(busy4), 32'(0));
    chk("rst_done8", 32'(done8), 32'(0));
    @(negedge clk);
    #1 rst_n = 1'b1;
    run_cmp = 1'b1;

    // Mode operations
    step(1, 3'b001, 8'h09, 0, 0, 0); chk("t2_load", 32'(q4), 32'h9);
    step(1, 3'b010, 8'h00, 1, 0, 0); chk("t2_shl", 32'(q4), 32'h3);
    step(1, 3'b001, 8'h09, 0, 0, 0);
    step(1, 3'b011, 8'h00, 0, 0, 0); chk("t2_shr", 32'(q4), 32'h4);
    step(1, 3'b001, 8'h09, 0, 0, 0);
    step(1, 3'b100, 8'h00, 0, 0, 0); chk("t2_rol", 32'(q4), 32'h3);
    step(1, 3'b001, 8'h09, 0, 0, 0);
    step(1, 3'b101, 8'h00, 0, 0, 0); chk("t2_ror", 32'(q4), 32'hC);

    // Burst of 1011, sin_r=0
    step(1, 3'b000, 8'h0B, 0, 0, 1);
    chk("t3_load", 32'(q4), 32'hB);
    chk("t3_sout0", 32'(sl4), 32'(1));
    chk("t3_busy0", 32'(busy4), 32'(1));
    exp_q[0] = 4'h5; exp_q[1] = 4'h2; exp_q[2] = 4'h1;
    for (int i = 0; i < 3; i++) begin
      step(1, 3'b000, 8'h00, 0, 0, 0);
      chk("t3_q", 32'(q4), 32'(exp_q[i]));
      chk("t3_busy", 32'(busy4), 32'(1));
      chk("t3_done_lo", 32'(done4), 32'(0));
    end
    step(1, 3'b000, 8'h00, 0, 0, 0);
    chk("t3_end_busy", 32'(busy4), 32'(0));
    chk("t3_end_done", 32'(done4), 32'(1));
    chk("t3_end_q", 32'(q4), 32'h1);
    step(0, 3'b000, 8'h00, 0, 0, 0);
    chk("t3_done_clr_en0", 32'(done4), 32'(0));
    wait_idle8();

    // Pause mid-burst; start/CLR during busy and at busy-fall are ignored
    step(1, 3'b000, 8'h06, 0, 0, 1); chk("t4_load", 32'(q4), 32'h6);
    step(1, 3'b000, 8'h00, 0, 1, 0); chk("t4_sh1", 32'(q4), 32'hB);
    for (int i = 0; i < 3; i++) begin
      step(0, 3'b110, 8'h00, 0, 1, 1);
      chk("t4_frozen_q", 32'(q4), 32'hB);
      chk("t4_frozen_busy", 32'(busy4), 32'(1));
    end
    step(1, 3'b110, 8'h00, 0, 1, 1); chk("t4_sh2", 32'(q4), 32'hD);
    step(1, 3'b110, 8'h00, 0, 1, 1); chk("t4_sh3", 32'(q4), 32'hE);
    chk("t4_busy_last", 32'(busy4), 32'(1));
    step(1, 3'b110, 8'h00, 0, 1, 1);
    chk("t4_fall_q", 32'(q4), 32'hE);
    chk("t4_fall_busy", 32'(busy4), 32'(0));
    chk("t4_fall_done", 32'(done4), 32'(1));
    step(1, 3'b000, 8'h00, 0, 0, 0);
    chk("t4_after_done", 32'(done4), 32'(0));
    chk("t4_after_busy", 32'(busy4), 32'(0));

    // Reserved mode, disabled load, clear
    step(1, 3'b111, 8'h01, 1, 1, 0); chk("t5_rsvd", 32'(q4), 32'hE);
    step(0, 3'b001, 8'h01, 0, 0, 0); chk("t5_en0", 32'(q4), 32'hE);
    step(1, 3'b110, 8'h01, 0, 0, 0); chk("t5_clr", 32'(q4), 32'h0);
    wait_idle8();

    // Async reset mid-burst with q=F
    step(1, 3'b000, 8'h0F, 0, 1, 1);
    step(1, 3'b000, 8'h00, 0, 1, 0);
    chk("t1_pre_q", 32'(q4), 32'hF);
    rst_n = 1'b0;
    #1;
    chk("t1_q4", 32'(q4), 32'h0);
    chk("t1_busy4", 32'(busy4), 32'(0));
    chk("t1_done4", 32'(done4), 32'(0));
    chk("t1_q8", 32'(q8), 32'hA5);
    chk("t1_busy8", 32'(busy8), 32'(0));
    @(negedge clk);
    #1 rst_n = 1'b1;
    step(1, 3'b000, 8'h00, 0, 0, 0);
    chk("t1_no_done", 32'(done4), 32'(0));

    // 8-bit burst of 3C: 8 busy cycles, LSB-first serial stream
    step(1, 3'b000, 8'h3C, 0, 0, 1);
    chk("t6_load", 32'(q8), 32'h3C);
    nb8 = 0;
    ser = 8'h00;
    for (int i = 0; i < 20; i++) begin
      if (!busy8) break;
      if (nb8 < 8) ser[nb8] = sl8;
      nb8++;
      step(1, 3'b000, 8'h00, 0, 0, 0);
    end
    chk("t6_busy_cycles", 32'(nb8), 32'(8));
    chk("t6_serial", 32'(ser), 32'h3C);
    chk("t6_done", 32'(done8), 32'(1));

    // Randomized traffic with occasional async reset
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 8) != 0, 3'($urandom % 8), 8'($urandom),
           1'($urandom % 2), 1'($urandom % 2), ($urandom % 5) == 0);
      if (($urandom % 300) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
